mdu_unit: RTL

- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle ALU for the pipelined CPU.
- Sits beside the ALU in the EX stage and owns the HI/LO register pair.
- Accepts mult/multu/div/divu/mthi/mtlo commands.
- Models a fixed per-operation latency with a busy flag that the hazard unit uses to stall mfhi/mflo and new MDU instructions.

---
 rtl/mdu_pkg.sv | 46 ++++
 rtl/mdu_if.sv | 29 ++
 rtl/mdu_core.sv | 89 ++++++++
 rtl/mdu_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the MDUOp command encoding, the two-state view of the
// busy counter, and helpers that classify commands and pick latencies.
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD  = 3'd7;

  // The unit's state lives in its counter; this enum names the two views.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for commands that compute a new HI/LO pair and take busy cycles.
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    logic result;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: result = 1'b1;
      default:                            result = 1'b0;
    endcase
    return result;
  endfunction

  // Busy-cycle count loaded into the counter when a command is accepted.
  function automatic int unsigned op_latency(input logic [OP_W-1:0] op,
                                             input int unsigned mult_cycles,
                                             input int unsigned div_cycles);
    int unsigned result;
    case (op)
      OP_MULT, OP_MULTU: result = mult_cycles;
      OP_DIV, OP_DIVU:   result = div_cycles;
      default:           result = 32'd0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: command/result bundle between the EX stage and the MDU.
//   start  - command strobe          MDUOp - command code
//   A, B   - operands (rs, rt)       busy  - operation in flight
//   HI, LO - architectural HI/LO registers
// master: the pipeline side (drives commands); slave: the MDU.
interface mdu_if #(
  parameter int WIDTH = 32
);
  import mdu_pkg::*;

  logic             start;
  logic [OP_W-1:0]  MDUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, MDUOp, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, MDUOp, A, B,
    output busy, HI, LO
  );

endinterface

// File: rtl/mdu_core.sv
// mdu_core: combinational multiply/divide datapath.
//   A, B    in  operands (multiplicand/dividend, multiplier/divisor)
//   MDUOp   in  command code selecting signed/unsigned mult/div
//   res_hi  out high product word or remainder
//   res_lo  out low product word or quotient
// Divide by zero yields quotient all-ones and remainder A; signed
// most-negative / -1 yields quotient most-negative and remainder 0.
module mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]          A,
  input  logic [WIDTH-1:0]          B,
  input  logic [mdu_pkg::OP_W-1:0]  MDUOp,
  output logic [WIDTH-1:0]          res_hi,
  output logic [WIDTH-1:0]          res_lo
);
  import mdu_pkg::*;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   b_safe_s;
  logic [WIDTH-1:0]   b_safe_u;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quot_u;
  logic [WIDTH-1:0]   rem_u;

  // Full-width products: operands are extended to 2*WIDTH first.
  assign prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign div_zero = (B == '0);
  assign div_ovf  = (A == MOST_NEG) && (B == '1);

  // Steer the dividers away from their undefined corners. For the signed
  // overflow case dividing by one already gives quotient=A, remainder=0.
  assign b_safe_s = (div_zero || div_ovf) ? ONE : B;
  assign b_safe_u = div_zero ? ONE : B;

  // Signed / and % truncate toward zero; remainder follows the dividend.
  assign quot_s = $signed(A) / $signed(b_safe_s);
  assign rem_s  = $signed(A) % $signed(b_safe_s);
  assign quot_u = A / b_safe_u;
  assign rem_u  = A % b_safe_u;

  // Select the result pair for the requested command.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (MDUOp)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        if (div_zero) begin
          res_hi = A;
          res_lo = '1;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_hi = A;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset; aborts any operation
//   bus    slave side of mdu_if (start/MDUOp/A/B in, busy/HI/LO out)
// The result is computed at acceptance and parked in shadow registers;
// a down-counter models latency and HI/LO update on its 1->0 edge.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  import mdu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next;
  logic             busy_r;
  logic [WIDTH-1:0] sh_hi_r;
  logic [WIDTH-1:0] sh_lo_r;
  logic [WIDTH-1:0] sh_hi_next;
  logic [WIDTH-1:0] sh_lo_next;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  mdu_state_e       state;

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .A      (bus.A),
    .B      (bus.B),
    .MDUOp  (bus.MDUOp),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign state = (count_r != '0) ? ST_RUN : ST_IDLE;

  // Next-state: accept commands when idle, count down and commit when running.
  always_comb begin
    count_next = count_r;
    sh_hi_next = sh_hi_r;
    sh_lo_next = sh_lo_r;
    hi_next    = hi_r;
    lo_next    = lo_r;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sh_hi_next = res_hi;
              sh_lo_next = res_lo;
              count_next = CNT_W'(op_latency(bus.MDUOp, MULT_CYCLES, DIV_CYCLES));
            end
            OP_MTHI: hi_next = bus.A;
            OP_MTLO: lo_next = bus.A;
            default: count_next = count_r;
          endcase
        end else begin
          count_next = count_r;
        end
      end
      ST_RUN: begin
        // A start while running is ignored: only the countdown proceeds.
        count_next = count_r - CNT_ONE;
        if (count_r == CNT_ONE) begin
          hi_next = sh_hi_r;
          lo_next = sh_lo_r;
        end else begin
          hi_next = hi_r;
          lo_next = lo_r;
        end
      end
      default: count_next = '0;
    endcase
  end

  // State register: reset clears everything, discarding any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      busy_r  <= 1'b0;
      sh_hi_r <= '0;
      sh_lo_r <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      count_r <= count_next;
      busy_r  <= (count_next != '0);
      sh_hi_r <= sh_hi_next;
      sh_lo_r <= sh_lo_next;
      hi_r    <= hi_next;
      lo_r    <= lo_next;
    end
  end

  assign bus.busy = busy_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

endmodule
